// File: rtl/mem_arbiter_2to1.sv
// -----------------------------------------------------------------------------
// mem_arbiter_2to1
//
// Shares one memory with a separate write port and a 1-cycle registered read
// port between two requesters:
//   port A : data/LSU side, has priority on conflicts
//   port B : fetch side, protected by a starvation counter
// A read and a write can both be granted in the same cycle because they use
// different memory ports. Read data coming back from the memory is routed to
// the port that issued the read.
//
// Handshake (both request ports): a request transfers in a cycle where
// valid_i & ready_o are both high. ready_o is combinational from valid_i/we_i
// and the arbitration state; a requester must not make valid_i depend on
// ready_o and holds valid/we/addr/wdata stable until ready_o is seen. Read
// responses have no backpressure: rsp_valid_o pulses for one cycle exactly one
// cycle after the read was granted.
//
// Optional feature macro: MEM_ARB_WR_FWD_EN
//   defined   : a granted read and a granted write to the same in-range
//               address in the same cycle return the new write data
//   undefined : such a read returns the memory's old contents
//
// Parameters
//   DataWidth   : data word width
//   NumEntries  : memory depth, address width AW = $clog2(NumEntries)
//   StarveLimit : conflict losses by B before B is forced to win (>= 1)
//
// Ports
//   clk_i, reset_ni              clock, synchronous active-low reset
//   a_valid_i / a_ready_o        port A request handshake
//   a_we_i, a_addr_i, a_wdata_i  port A request payload (1 = write)
//   a_rsp_valid_o, a_rsp_data_o  port A read response
//   b_*                          same set for port B
//   mem_reset_o                  memory reset, active high
//   mem_wr_valid_o/addr_o/data_o memory write port
//   mem_rd_valid_o/addr_o        memory read request
//   mem_rd_data_i                memory registered read data
// -----------------------------------------------------------------------------
module mem_arbiter_2to1 #(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned NumEntries  = 31,
  parameter int unsigned StarveLimit = 4,
  localparam int unsigned AW = (NumEntries > 1) ? $clog2(NumEntries) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,

  input  logic                 a_valid_i,
  output logic                 a_ready_o,
  input  logic                 a_we_i,
  input  logic [AW-1:0]        a_addr_i,
  input  logic [DataWidth-1:0] a_wdata_i,
  output logic                 a_rsp_valid_o,
  output logic [DataWidth-1:0] a_rsp_data_o,

  input  logic                 b_valid_i,
  output logic                 b_ready_o,
  input  logic                 b_we_i,
  input  logic [AW-1:0]        b_addr_i,
  input  logic [DataWidth-1:0] b_wdata_i,
  output logic                 b_rsp_valid_o,
  output logic [DataWidth-1:0] b_rsp_data_o,

  output logic                 mem_reset_o,
  output logic                 mem_wr_valid_o,
  output logic [AW-1:0]        mem_wr_addr_o,
  output logic [DataWidth-1:0] mem_wr_data_o,
  output logic                 mem_rd_valid_o,
  output logic [AW-1:0]        mem_rd_addr_o,
  input  logic [DataWidth-1:0] mem_rd_data_i
);

  localparam int unsigned SW = $clog2(StarveLimit + 1);
  localparam logic [SW-1:0] StarveMax = SW'(StarveLimit);

  // Addresses at or above NumEntries are accepted but never reach the memory.
  function automatic logic addr_in_range(input logic [AW-1:0] addr);
    return (32'(addr) < NumEntries);
  endfunction

  // Arbitration state and read-response route.
  logic [SW-1:0]        starve_cnt_q, starve_cnt_d;
  logic                 rsp_pend_q, rsp_pend_d;
  logic                 rsp_port_b_q, rsp_port_b_d;
  logic                 rsp_oor_q, rsp_oor_d;

  logic                 conflict;
  logic                 b_wins;
  logic                 a_gnt, b_gnt;

  logic                 wr_gnt, rd_gnt, rd_is_b;
  logic [AW-1:0]        wr_addr, rd_addr;
  logic [DataWidth-1:0] wr_data;
  logic                 wr_in_range, rd_in_range;

  logic                 rsp_fire;
  logic [DataWidth-1:0] rsp_data;

  // ---------------------------------------------------------------------------
  // Grant decision. Only same-direction requests collide; B wins a collision
  // only once it has lost StarveLimit times in a row.
  // ---------------------------------------------------------------------------
  always_comb begin
    conflict = a_valid_i & b_valid_i & (a_we_i == b_we_i);
    b_wins   = (starve_cnt_q == StarveMax);
    a_gnt    = reset_ni & a_valid_i & ~(conflict & b_wins);
    b_gnt    = reset_ni & b_valid_i & ~(conflict & ~b_wins);
  end

  assign a_ready_o = a_gnt;
  assign b_ready_o = b_gnt;

  // ---------------------------------------------------------------------------
  // Steer the (at most one) granted write and (at most one) granted read.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_gnt  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (a_gnt && a_we_i) begin
      wr_gnt  = 1'b1;
      wr_addr = a_addr_i;
      wr_data = a_wdata_i;
    end else if (b_gnt && b_we_i) begin
      wr_gnt  = 1'b1;
      wr_addr = b_addr_i;
      wr_data = b_wdata_i;
    end

    rd_gnt  = 1'b0;
    rd_addr = '0;
    rd_is_b = 1'b0;
    if (a_gnt && !a_we_i) begin
      rd_gnt  = 1'b1;
      rd_addr = a_addr_i;
    end else if (b_gnt && !b_we_i) begin
      rd_gnt  = 1'b1;
      rd_addr = b_addr_i;
      rd_is_b = 1'b1;
    end

    wr_in_range = addr_in_range(wr_addr);
    rd_in_range = addr_in_range(rd_addr);
  end

  assign mem_reset_o    = ~reset_ni;
  assign mem_wr_valid_o = wr_gnt & wr_in_range;
  assign mem_wr_addr_o  = mem_wr_valid_o ? wr_addr : '0;
  assign mem_wr_data_o  = mem_wr_valid_o ? wr_data : '0;
  assign mem_rd_valid_o = rd_gnt & rd_in_range;
  assign mem_rd_addr_o  = mem_rd_valid_o ? rd_addr : '0;

  // ---------------------------------------------------------------------------
  // Next state: starvation counter and response route.
  // ---------------------------------------------------------------------------
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (b_gnt) begin
      starve_cnt_d = '0;
    end else if (b_valid_i && (starve_cnt_q != StarveMax)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end

    rsp_pend_d   = rd_gnt;
    rsp_port_b_d = rd_is_b;
    // Out-of-range reads still produce a response, but with zero data.
    rsp_oor_d    = rd_gnt & ~rd_in_range;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      starve_cnt_q <= '0;
      rsp_pend_q   <= 1'b0;
      rsp_port_b_q <= 1'b0;
      rsp_oor_q    <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rsp_pend_q   <= rsp_pend_d;
      rsp_port_b_q <= rsp_port_b_d;
      rsp_oor_q    <= rsp_oor_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Response data source.
  // ---------------------------------------------------------------------------
`ifdef MEM_ARB_WR_FWD_EN
  // The memory returns old contents when read and write hit the same entry in
  // one cycle; remember the write data so the read sees the new value.
  logic                 fwd_hit_q, fwd_hit_d;
  logic [DataWidth-1:0] fwd_data_q, fwd_data_d;

  always_comb begin
    fwd_hit_d  = mem_wr_valid_o & mem_rd_valid_o & (wr_addr == rd_addr);
    fwd_data_d = fwd_hit_d ? wr_data : fwd_data_q;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  assign rsp_data = rsp_oor_q ? '0 : (fwd_hit_q ? fwd_data_q : mem_rd_data_i);
`else
  assign rsp_data = rsp_oor_q ? '0 : mem_rd_data_i;
`endif

  // Gating with reset_ni drops a response that was in flight when reset hit.
  assign rsp_fire      = reset_ni & rsp_pend_q;
  assign a_rsp_valid_o = rsp_fire & ~rsp_port_b_q;
  assign b_rsp_valid_o = rsp_fire & rsp_port_b_q;
  assign a_rsp_data_o  = a_rsp_valid_o ? rsp_data : '0;
  assign b_rsp_data_o  = b_rsp_valid_o ? rsp_data : '0;

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter_2to1
//
// Bench for mem_arbiter_2to1 with a behavioural registered-read memory hooked
// to the memory ports. Directed scenarios check fixed expected values; a
// randomized run checks every output each cycle against a reference model
// built from the arbitration rules (shadow memory, loss counter, response
// queue).
// -----------------------------------------------------------------------------
module tb_mem_arbiter_2to1;

  localparam int DW = 32;
  localparam int NE = 31;
  localparam int SL = 4;
  localparam int AW = $clog2(NE);

`ifdef MEM_ARB_WR_FWD_EN
  localparam logic [DW-1:0] RawExp = 32'h11;
`else
  localparam logic [DW-1:0] RawExp = 32'h22;
`endif

  // ---------------------------------------------------------------- clock/reset
  logic clk_i;
  logic reset_ni;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // ---------------------------------------------------------------- DUT
  logic          a_valid_i, a_ready_o, a_we_i, a_rsp_valid_o;
  logic [AW-1:0] a_addr_i;
  logic [DW-1:0] a_wdata_i, a_rsp_data_o;
  logic          b_valid_i, b_ready_o, b_we_i, b_rsp_valid_o;
  logic [AW-1:0] b_addr_i;
  logic [DW-1:0] b_wdata_i, b_rsp_data_o;
  logic          mem_reset_o, mem_wr_valid_o, mem_rd_valid_o;
  logic [AW-1:0] mem_wr_addr_o, mem_rd_addr_o;
  logic [DW-1:0] mem_wr_data_o, mem_rd_data_i;

  mem_arbiter_2to1 #(
    .DataWidth  (DW),
    .NumEntries (NE),
    .StarveLimit(SL)
  ) dut (
    .clk_i         (clk_i),
    .reset_ni      (reset_ni),
    .a_valid_i     (a_valid_i),
    .a_ready_o     (a_ready_o),
    .a_we_i        (a_we_i),
    .a_addr_i      (a_addr_i),
    .a_wdata_i     (a_wdata_i),
    .a_rsp_valid_o (a_rsp_valid_o),
    .a_rsp_data_o  (a_rsp_data_o),
    .b_valid_i     (b_valid_i),
    .b_ready_o     (b_ready_o),
    .b_we_i        (b_we_i),
    .b_addr_i      (b_addr_i),
    .b_wdata_i     (b_wdata_i),
    .b_rsp_valid_o (b_rsp_valid_o),
    .b_rsp_data_o  (b_rsp_data_o),
    .mem_reset_o   (mem_reset_o),
    .mem_wr_valid_o(mem_wr_valid_o),
    .mem_wr_addr_o (mem_wr_addr_o),
    .mem_wr_data_o (mem_wr_data_o),
    .mem_rd_valid_o(mem_rd_valid_o),
    .mem_rd_addr_o (mem_rd_addr_o),
    .mem_rd_data_i (mem_rd_data_i)
  );

  // Memory attached to the DUT: write port and registered read returning the
  // contents from before a same-cycle write.
  logic [DW-1:0] env_mem [0:31];

  always @(posedge clk_i) begin
    if (mem_wr_valid_o) env_mem[mem_wr_addr_o] <= mem_wr_data_o;
    if (mem_reset_o) mem_rd_data_i <= '0;
    else if (mem_rd_valid_o) mem_rd_data_i <= env_mem[mem_rd_addr_o];
  end

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic          a_rdy;
    logic          b_rdy;
    logic          wr_v;
    logic [AW-1:0] wr_a;
    logic [DW-1:0] wr_d;
    logic          rd_v;
    logic [AW-1:0] rd_a;
    logic          has_r;
    logic          rd_b;
    logic          rd_oor;
    logic [AW-1:0] ra;
  } exp_t;

  int            m_starve;
  logic [DW-1:0] ref_mem [0:31];
  logic [DW:0]   exp_q [$];   // {port_is_b, data}

  int n_tests;
  int n_fails;

  // Who is granted this cycle, and what the memory ports must show.
  function automatic exp_t model_eval();
    exp_t          e;
    logic          has_w;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    e     = '0;
    has_w = 1'b0;
    wa    = '0;
    wd    = '0;
    if (!reset_ni) return e;
    if (a_valid_i && b_valid_i && (a_we_i == b_we_i)) begin
      if (m_starve >= SL) e.b_rdy = 1'b1;
      else                e.a_rdy = 1'b1;
    end else begin
      e.a_rdy = a_valid_i;
      e.b_rdy = b_valid_i;
    end
    if (e.a_rdy && a_we_i) begin has_w = 1'b1; wa = a_addr_i; wd = a_wdata_i; end
    if (e.b_rdy && b_we_i) begin has_w = 1'b1; wa = b_addr_i; wd = b_wdata_i; end
    if (e.a_rdy && !a_we_i) begin e.has_r = 1'b1; e.ra = a_addr_i; e.rd_b = 1'b0; end
    if (e.b_rdy && !b_we_i) begin e.has_r = 1'b1; e.ra = b_addr_i; e.rd_b = 1'b1; end
    if (has_w && int'(wa) < NE) begin
      e.wr_v = 1'b1;
      e.wr_a = wa;
      e.wr_d = wd;
    end
    if (e.has_r) begin
      e.rd_oor = !(int'(e.ra) < NE);
      if (!e.rd_oor) begin
        e.rd_v = 1'b1;
        e.rd_a = e.ra;
      end
    end
    return e;
  endfunction

  // Advance model state across the coming clock edge.
  task automatic model_commit(input exp_t e);
    logic [DW-1:0] d;
    if (!reset_ni) begin
      m_starve = 0;
      exp_q.delete();
      return;
    end
    if (e.b_rdy) m_starve = 0;
    else if (b_valid_i && m_starve < SL) m_starve++;
    if (e.has_r) begin
      if (e.rd_oor) d = '0;
      else begin
        d = ref_mem[e.ra];
`ifdef MEM_ARB_WR_FWD_EN
        if (e.wr_v && e.wr_a == e.ra) d = e.wr_d;
`endif
      end
      exp_q.push_back({e.rd_b, d});
    end
    if (e.wr_v) ref_mem[e.wr_a] = e.wr_d;
  endtask

  // Response expected this cycle (reads granted last cycle).
  task automatic model_rsp(output logic av, output logic [DW-1:0] ad,
                           output logic bv, output logic [DW-1:0] bd);
    logic [DW:0] r;
    av = 1'b0; ad = '0; bv = 1'b0; bd = '0;
    if (!reset_ni) begin
      exp_q.delete();
      return;
    end
    if (exp_q.size() != 0) begin
      r = exp_q.pop_front();
      if (r[DW]) begin bv = 1'b1; bd = r[DW-1:0]; end
      else       begin av = 1'b1; ad = r[DW-1:0]; end
    end
  endtask

  task automatic model_step();
    logic          av, bv;
    logic [DW-1:0] ad, bd;
    model_rsp(av, ad, bv, bd);
    model_commit(model_eval());
  endtask

  // ---------------------------------------------------------------- driver
  task automatic drive(input logic rst_n,
                       input logic av, input logic awe, input logic [AW-1:0] aa,
                       input logic [DW-1:0] ad,
                       input logic bv, input logic bwe, input logic [AW-1:0] ba,
                       input logic [DW-1:0] bd);
    @(negedge clk_i);
    reset_ni  = rst_n;
    a_valid_i = av;  a_we_i = awe; a_addr_i = aa; a_wdata_i = ad;
    b_valid_i = bv;  b_we_i = bwe; b_addr_i = ba; b_wdata_i = bd;
    #1;
  endtask

  task automatic drive_idle();
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, 1'b0, 5'd1, '0, 1'b1, 1'b0, 5'd2, '0);
      n_tests++; if (a_ready_o !== 1'b0) begin n_fails++; $display("FAIL rst_a_ready: got %b want 0", a_ready_o); end
      n_tests++; if (b_ready_o !== 1'b0) begin n_fails++; $display("FAIL rst_b_ready: got %b want 0", b_ready_o); end
      n_tests++; if (mem_wr_valid_o !== 1'b0) begin n_fails++; $display("FAIL rst_wr_valid: got %b want 0", mem_wr_valid_o); end
      n_tests++; if (mem_rd_valid_o !== 1'b0) begin n_fails++; $display("FAIL rst_rd_valid: got %b want 0", mem_rd_valid_o); end
      n_tests++; if (a_rsp_valid_o !== 1'b0 || a_rsp_data_o !== '0) begin n_fails++; $display("FAIL rst_a_rsp: got %b/%h want 0/0", a_rsp_valid_o, a_rsp_data_o); end
      n_tests++; if (b_rsp_valid_o !== 1'b0 || b_rsp_data_o !== '0) begin n_fails++; $display("FAIL rst_b_rsp: got %b/%h want 0/0", b_rsp_valid_o, b_rsp_data_o); end
      n_tests++; if (mem_reset_o !== 1'b1) begin n_fails++; $display("FAIL rst_mem_reset: got %b want 1", mem_reset_o); end
      model_step();
    end
    drive_idle();
    n_tests++; if (mem_reset_o !== 1'b0) begin n_fails++; $display("FAIL rst_release_mem_reset: got %b want 0", mem_reset_o); end
    n_tests++; if (a_ready_o !== 1'b0 || b_ready_o !== 1'b0) begin n_fails++; $display("FAIL rst_release_idle_ready: got %b%b want 00", a_ready_o, b_ready_o); end
    model_step();
  endtask

  task automatic test_write_read();
    drive(1'b1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
    n_tests++; if (a_ready_o !== 1'b1) begin n_fails++; $display("FAIL wr_a_ready: got %b want 1", a_ready_o); end
    n_tests++; if (mem_wr_valid_o !== 1'b1 || mem_wr_addr_o !== 5'd5 || mem_wr_data_o !== 32'hDEADBEEF) begin
      n_fails++; $display("FAIL wr_port: got %b/%0d/%h want 1/5/deadbeef", mem_wr_valid_o, mem_wr_addr_o, mem_wr_data_o); end
    n_tests++; if (mem_rd_valid_o !== 1'b0 || mem_rd_addr_o !== '0) begin n_fails++; $display("FAIL wr_rd_idle: got %b/%0d want 0/0", mem_rd_valid_o, mem_rd_addr_o); end
    model_step();
    drive(1'b1, 1'b1, 1'b0, 5'd5, '0, 1'b0, 1'b0, '0, '0);
    n_tests++; if (a_ready_o !== 1'b1) begin n_fails++; $display("FAIL rd_a_ready: got %b want 1", a_ready_o); end
    n_tests++; if (mem_rd_valid_o !== 1'b1 || mem_rd_addr_o !== 5'd5) begin n_fails++; $display("FAIL rd_port: got %b/%0d want 1/5", mem_rd_valid_o, mem_rd_addr_o); end
    n_tests++; if (mem_wr_valid_o !== 1'b0 || mem_wr_data_o !== '0) begin n_fails++; $display("FAIL rd_wr_idle: got %b/%h want 0/0", mem_wr_valid_o, mem_wr_data_o); end
    model_step();
    drive_idle();
    n_tests++; if (a_rsp_valid_o !== 1'b1 || a_rsp_data_o !== 32'hDEADBEEF) begin n_fails++; $display("FAIL rd_a_rsp: got %b/%h want 1/deadbeef", a_rsp_valid_o, a_rsp_data_o); end
    n_tests++; if (b_rsp_valid_o !== 1'b0) begin n_fails++; $display("FAIL rd_b_rsp: got %b want 0", b_rsp_valid_o); end
    model_step();
    drive_idle();
    n_tests++; if (a_rsp_valid_o !== 1'b0) begin n_fails++; $display("FAIL rd_a_rsp_once: got %b want 0", a_rsp_valid_o); end
    model_step();
  endtask

  task automatic test_starvation();
    logic          want_b, prev_b;
    logic [AW-1:0] want_addr;
    logic          av, bv;
    logic [DW-1:0] ad, bd;
    prev_b = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i < 15) drive(1'b1, 1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0, AW'(i + 10), '0);
      else        drive_idle();
      model_rsp(av, ad, bv, bd);
      if (i < 15) begin
        // Four wins for A, then one for B, repeating.
        want_b    = ((i % 5) == 4);
        want_addr = want_b ? AW'(i + 10) : AW'(i);
        n_tests++; if (a_ready_o !== !want_b || b_ready_o !== want_b) begin
          n_fails++; $display("FAIL starve_grant cyc %0d: got a=%b b=%b want a=%b b=%b", i, a_ready_o, b_ready_o, !want_b, want_b); end
        n_tests++; if (mem_rd_valid_o !== 1'b1 || mem_rd_addr_o !== want_addr) begin
          n_fails++; $display("FAIL starve_rd_addr cyc %0d: got %b/%0d want 1/%0d", i, mem_rd_valid_o, mem_rd_addr_o, want_addr); end
      end
      if (i > 0) begin
        n_tests++; if (a_rsp_valid_o !== !prev_b || b_rsp_valid_o !== prev_b) begin
          n_fails++; $display("FAIL starve_route cyc %0d: got a=%b b=%b want a=%b b=%b", i, a_rsp_valid_o, b_rsp_valid_o, !prev_b, prev_b); end
        n_tests++; if (a_rsp_data_o !== ad || b_rsp_data_o !== bd) begin
          n_fails++; $display("FAIL starve_rsp_data cyc %0d: got %h/%h want %h/%h", i, a_rsp_data_o, b_rsp_data_o, ad, bd); end
      end
      prev_b = want_b;
      model_commit(model_eval());
    end
  endtask

  task automatic test_rw_same_addr();
    drive(1'b1, 1'b1, 1'b1, 5'd7, 32'h22, 1'b0, 1'b0, '0, '0);
    n_tests++; if (a_ready_o !== 1'b1) begin n_fails++; $display("FAIL raw_setup_ready: got %b want 1", a_ready_o); end
    model_step();
    drive(1'b1, 1'b1, 1'b1, 5'd7, 32'h11, 1'b1, 1'b0, 5'd7, '0);
    n_tests++; if (a_ready_o !== 1'b1 || b_ready_o !== 1'b1) begin n_fails++; $display("FAIL raw_both_ready: got %b%b want 11", a_ready_o, b_ready_o); end
    n_tests++; if (mem_wr_valid_o !== 1'b1 || mem_wr_addr_o !== 5'd7 || mem_wr_data_o !== 32'h11) begin
      n_fails++; $display("FAIL raw_wr_port: got %b/%0d/%h want 1/7/11", mem_wr_valid_o, mem_wr_addr_o, mem_wr_data_o); end
    n_tests++; if (mem_rd_valid_o !== 1'b1 || mem_rd_addr_o !== 5'd7) begin n_fails++; $display("FAIL raw_rd_port: got %b/%0d want 1/7", mem_rd_valid_o, mem_rd_addr_o); end
    model_step();
    drive(1'b1, 1'b1, 1'b0, 5'd7, '0, 1'b0, 1'b0, '0, '0);
    n_tests++; if (b_rsp_valid_o !== 1'b1 || b_rsp_data_o !== RawExp) begin n_fails++; $display("FAIL raw_b_rsp: got %b/%h want 1/%h", b_rsp_valid_o, b_rsp_data_o, RawExp); end
    n_tests++; if (a_rsp_valid_o !== 1'b0) begin n_fails++; $display("FAIL raw_a_rsp_quiet: got %b want 0", a_rsp_valid_o); end
    model_step();
    drive_idle();
    n_tests++; if (a_rsp_valid_o !== 1'b1 || a_rsp_data_o !== 32'h11) begin n_fails++; $display("FAIL raw_a_reread: got %b/%h want 1/11", a_rsp_valid_o, a_rsp_data_o); end
    model_step();
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 1'b1, 1'b1, AW'(NE), 32'hCAFE, 1'b1, 1'b0, AW'(NE), '0);
    n_tests++; if (a_ready_o !== 1'b1 || b_ready_o !== 1'b1) begin n_fails++; $display("FAIL oor_ready: got %b%b want 11", a_ready_o, b_ready_o); end
    n_tests++; if (mem_wr_valid_o !== 1'b0 || mem_wr_addr_o !== '0) begin n_fails++; $display("FAIL oor_wr_drop: got %b/%0d want 0/0", mem_wr_valid_o, mem_wr_addr_o); end
    n_tests++; if (mem_rd_valid_o !== 1'b0) begin n_fails++; $display("FAIL oor_rd_valid: got %b want 0", mem_rd_valid_o); end
    model_step();
    drive_idle();
    n_tests++; if (b_rsp_valid_o !== 1'b1 || b_rsp_data_o !== '0) begin n_fails++; $display("FAIL oor_b_rsp: got %b/%h want 1/0", b_rsp_valid_o, b_rsp_data_o); end
    n_tests++; if (a_rsp_valid_o !== 1'b0) begin n_fails++; $display("FAIL oor_a_rsp: got %b want 0", a_rsp_valid_o); end
    model_step();
  endtask

  task automatic test_reset_mid_read();
    logic [DW-1:0] w;
    w = $urandom;
    drive(1'b1, 1'b1, 1'b1, 5'd0, w, 1'b0, 1'b0, '0, '0);
    model_step();
    drive(1'b1, 1'b1, 1'b0, 5'd0, '0, 1'b0, 1'b0, '0, '0);
    n_tests++; if (a_ready_o !== 1'b1) begin n_fails++; $display("FAIL mid_rd_ready: got %b want 1", a_ready_o); end
    model_step();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    n_tests++; if (a_rsp_valid_o !== 1'b0) begin n_fails++; $display("FAIL mid_rsp_in_reset: got %b want 0", a_rsp_valid_o); end
    model_step();
    drive_idle();
    n_tests++; if (a_rsp_valid_o !== 1'b0 || b_rsp_valid_o !== 1'b0) begin n_fails++; $display("FAIL mid_rsp_dropped: got %b%b want 00", a_rsp_valid_o, b_rsp_valid_o); end
    model_step();
    drive(1'b1, 1'b1, 1'b0, 5'd0, '0, 1'b0, 1'b0, '0, '0);
    n_tests++; if (a_ready_o !== 1'b1 || mem_rd_valid_o !== 1'b1) begin n_fails++; $display("FAIL mid_post_rd: got %b/%b want 1/1", a_ready_o, mem_rd_valid_o); end
    model_step();
    drive_idle();
    n_tests++; if (a_rsp_valid_o !== 1'b1 || a_rsp_data_o !== w) begin n_fails++; $display("FAIL mid_post_rsp: got %b/%h want 1/%h", a_rsp_valid_o, a_rsp_data_o, w); end
    model_step();
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 15) == 0) return AW'(NE);
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    exp_t          e;
    logic          av, bv;
    logic [DW-1:0] ad, bd;
    logic          ra_v, ra_we, rb_v, rb_we, a_hold, b_hold;
    logic [AW-1:0] ra_a, rb_a;
    logic [DW-1:0] ra_d, rb_d;
    a_hold = 1'b0; b_hold = 1'b0;
    ra_v = 1'b0; ra_we = 1'b0; ra_a = '0; ra_d = '0;
    rb_v = 1'b0; rb_we = 1'b0; rb_a = '0; rb_d = '0;
    for (int c = 0; c < 401; c++) begin
      // A requester keeps its request unchanged until it is granted.
      if (!a_hold) begin
        ra_v = (c < 400) && ($urandom_range(0, 3) != 0);
        ra_we = 1'(($urandom_range(0, 2)) == 0); ra_a = pick_addr(); ra_d = $urandom;
      end
      if (!b_hold) begin
        rb_v = (c < 400) && ($urandom_range(0, 3) != 0);
        rb_we = 1'(($urandom_range(0, 2)) == 0); rb_a = pick_addr(); rb_d = $urandom;
      end
      if (c == 400) begin ra_v = 1'b0; rb_v = 1'b0; end
      drive(1'b1, ra_v, ra_we, ra_a, ra_d, rb_v, rb_we, rb_a, rb_d);
      model_rsp(av, ad, bv, bd);
      e = model_eval();
      n_tests++; if (a_ready_o !== e.a_rdy || b_ready_o !== e.b_rdy) begin
        n_fails++; $display("FAIL rnd_ready cyc %0d: got %b%b want %b%b", c, a_ready_o, b_ready_o, e.a_rdy, e.b_rdy); end
      n_tests++; if (mem_wr_valid_o !== e.wr_v || mem_wr_addr_o !== e.wr_a || mem_wr_data_o !== e.wr_d) begin
        n_fails++; $display("FAIL rnd_wr cyc %0d: got %b/%0d/%h want %b/%0d/%h", c, mem_wr_valid_o, mem_wr_addr_o, mem_wr_data_o, e.wr_v, e.wr_a, e.wr_d); end
      n_tests++; if (mem_rd_valid_o !== e.rd_v || mem_rd_addr_o !== e.rd_a) begin
        n_fails++; $display("FAIL rnd_rd cyc %0d: got %b/%0d want %b/%0d", c, mem_rd_valid_o, mem_rd_addr_o, e.rd_v, e.rd_a); end
      n_tests++; if (a_rsp_valid_o !== av || a_rsp_data_o !== ad) begin
        n_fails++; $display("FAIL rnd_a_rsp cyc %0d: got %b/%h want %b/%h", c, a_rsp_valid_o, a_rsp_data_o, av, ad); end
      n_tests++; if (b_rsp_valid_o !== bv || b_rsp_data_o !== bd) begin
        n_fails++; $display("FAIL rnd_b_rsp cyc %0d: got %b/%h want %b/%h", c, b_rsp_valid_o, b_rsp_data_o, bv, bd); end
      a_hold = ra_v && !e.a_rdy;
      b_hold = rb_v && !e.b_rdy;
      model_commit(e);
    end
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    n_tests  = 0;
    n_fails  = 0;
    m_starve = 0;
    reset_ni  = 1'b0;
    a_valid_i = 1'b0; a_we_i = 1'b0; a_addr_i = '0; a_wdata_i = '0;
    b_valid_i = 1'b0; b_we_i = 1'b0; b_addr_i = '0; b_wdata_i = '0;
    for (int i = 0; i < 32; i++) begin
      ref_mem[i] = $urandom;
      env_mem[i] = ref_mem[i];
    end

    test_reset();
    test_write_read();
    test_starvation();
    test_rw_same_addr();
    test_out_of_range();
    test_reset_mid_read();
    test_random();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
